// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// decode_stage: RV32I(M) decode with a small instruction queue and a registered
// output toward execute. Define DECODE_RVM_EN to decode the M extension.
// Rev 1.0
// ============================================================================
module decode_stage #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [31:0]      out_imm,
  output logic [4:0]       out_alu_ctl,
  output logic             out_alu_src1,
  output logic             out_alu_src2,
  output logic [1:0]       out_wb_sel,
  output logic             out_reg_wr,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic [2:0]       out_rw_type,
  output logic [5:0]       out_br,
  output logic             out_jal,
  output logic             out_jalr,
  output logic             out_illegal,
  output logic [CNT_W-1:0] fifo_count
);
  localparam int PTR_W = $clog2(DEPTH);

  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_REG    = 7'b0110011;

  localparam logic [4:0] c_ALU_ADD  = 5'd0;
  localparam logic [4:0] c_ALU_SUB  = 5'd1;
  localparam logic [4:0] c_ALU_AND  = 5'd10;
  localparam logic [4:0] c_ALU_OR   = 5'd11;
  localparam logic [4:0] c_ALU_XOR  = 5'd12;
  localparam logic [4:0] c_ALU_SLL  = 5'd14;
  localparam logic [4:0] c_ALU_SRL  = 5'd15;
  localparam logic [4:0] c_ALU_SRA  = 5'd16;
  localparam logic [4:0] c_ALU_SLTU = 5'd17;
  localparam logic [4:0] c_ALU_SLT  = 5'd18;
`ifdef DECODE_RVM_EN
  localparam logic [4:0] c_ALU_MUL  = 5'd2;
`endif

  logic [31:0]      r_q_inst [DEPTH];
  logic [XLEN-1:0]  r_q_pc   [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push, w_pop;
  logic [31:0] w_inst;
  logic [6:0]  w_op, w_f7;
  logic [2:0]  w_f3;
  logic [31:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j;
  logic [31:0] w_imm;
  logic [4:0]  w_alu_ctl;
  logic        w_src1, w_src2, w_reg_wr, w_mem_rd, w_mem_wr, w_jal, w_jalr, w_illegal;
  logic [1:0]  w_wb_sel;
  logic [2:0]  w_rw_type;
  logic [5:0]  w_br;

  // A flush frees the queue at the next edge, so fetch may keep offering.
  assign in_ready   = (r_count != CNT_W'(DEPTH)) | flush;
  assign w_push     = in_valid & in_ready;
  assign w_pop      = (r_count != '0) & (~out_valid | out_ready);
  assign fifo_count = r_count;

  assign w_inst  = r_q_inst[r_rd_ptr];
  assign w_op    = w_inst[6:0];
  assign w_f3    = w_inst[14:12];
  assign w_f7    = w_inst[31:25];
  assign w_imm_i = {{20{w_inst[31]}}, w_inst[31:20]};
  assign w_imm_s = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
  assign w_imm_b = {{19{w_inst[31]}}, w_inst[31], w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_imm_u = {w_inst[31:12], 12'h000};
  assign w_imm_j = {{11{w_inst[31]}}, w_inst[31], w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};

  function automatic logic [4:0] f_base_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    return c_ALU_ADD;
      3'd1:    return c_ALU_SLL;
      3'd2:    return c_ALU_SLT;
      3'd3:    return c_ALU_SLTU;
      3'd4:    return c_ALU_XOR;
      3'd5:    return c_ALU_SRL;
      3'd6:    return c_ALU_OR;
      default: return c_ALU_AND;
    endcase
  endfunction

  always_comb begin
    w_imm = '0; w_alu_ctl = c_ALU_ADD; w_src1 = 1'b0; w_src2 = 1'b0;
    w_wb_sel = 2'd0; w_reg_wr = 1'b0; w_mem_rd = 1'b0; w_mem_wr = 1'b0;
    w_rw_type = 3'd0; w_br = '0; w_jal = 1'b0; w_jalr = 1'b0; w_illegal = 1'b0;
    case (w_op)
      c_OP_LUI:   begin w_imm = w_imm_u; w_wb_sel = 2'd2; w_reg_wr = 1'b1; end
      c_OP_AUIPC: begin w_imm = w_imm_u; w_src1 = 1'b1; w_src2 = 1'b1; w_wb_sel = 2'd1; w_reg_wr = 1'b1; end
      c_OP_JAL:   begin w_imm = w_imm_j; w_src1 = 1'b1; w_src2 = 1'b1; w_reg_wr = 1'b1; w_jal = 1'b1; end
      c_OP_JALR:  begin w_imm = w_imm_i; w_src2 = 1'b1; w_reg_wr = 1'b1; w_jalr = 1'b1; end
      c_OP_BRANCH: begin
        w_imm = w_imm_b; w_src1 = 1'b1; w_src2 = 1'b1;
        case (w_f3)
          3'd0:    w_br = 6'b000001;
          3'd1:    w_br = 6'b000010;
          3'd4:    w_br = 6'b000100;
          3'd5:    w_br = 6'b001000;
          3'd6:    w_br = 6'b010000;
          3'd7:    w_br = 6'b100000;
          default: w_illegal = 1'b1;
        endcase
      end
      c_OP_LOAD: begin
        w_imm = w_imm_i; w_src2 = 1'b1; w_wb_sel = 2'd3; w_reg_wr = 1'b1;
        w_mem_rd = 1'b1; w_rw_type = w_f3;
        if (w_f3 == 3'd3 || w_f3 >= 3'd6) w_illegal = 1'b1;
      end
      c_OP_STORE: begin
        w_imm = w_imm_s; w_src2 = 1'b1; w_mem_wr = 1'b1; w_rw_type = w_f3;
        if (w_f3 > 3'd2) w_illegal = 1'b1;
      end
      c_OP_IMM: begin
        w_imm = w_imm_i; w_src2 = 1'b1; w_wb_sel = 2'd1; w_reg_wr = 1'b1;
        w_alu_ctl = f_base_alu(w_f3);
        if (w_f3 == 3'd1 && w_f7 != 7'h00) w_illegal = 1'b1;
        if (w_f3 == 3'd5) begin
          if (w_f7 == 7'h20)      w_alu_ctl = c_ALU_SRA;
          else if (w_f7 != 7'h00) w_illegal = 1'b1;
        end
      end
      c_OP_REG: begin
        w_wb_sel = 2'd1; w_reg_wr = 1'b1;
        case (w_f7)
          7'h00: w_alu_ctl = f_base_alu(w_f3);
          7'h20: begin
            if (w_f3 == 3'd0)      w_alu_ctl = c_ALU_SUB;
            else if (w_f3 == 3'd5) w_alu_ctl = c_ALU_SRA;
            else                   w_illegal = 1'b1;
          end
`ifdef DECODE_RVM_EN
          7'h01: w_alu_ctl = c_ALU_MUL + {2'b00, w_f3};
`endif
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_inst[1:0] != 2'b11) w_illegal = 1'b1;
    // Illegal words pass through inert: no side effects, no operands selected.
    if (w_illegal) begin
      w_imm = '0; w_alu_ctl = c_ALU_ADD; w_src1 = 1'b0; w_src2 = 1'b0;
      w_wb_sel = 2'd0; w_reg_wr = 1'b0; w_mem_rd = 1'b0; w_mem_wr = 1'b0;
      w_rw_type = 3'd0; w_br = '0; w_jal = 1'b0; w_jalr = 1'b0;
    end
    if (w_inst[11:7] == 5'd0) w_reg_wr = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_q_inst[r_wr_ptr] <= in_inst;
      r_q_pc[r_wr_ptr]   <= in_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0; out_valid <= 1'b0;
      out_pc <= '0; out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0; out_imm <= '0;
      out_alu_ctl <= '0; out_alu_src1 <= 1'b0; out_alu_src2 <= 1'b0; out_wb_sel <= '0;
      out_reg_wr <= 1'b0; out_mem_rd <= 1'b0; out_mem_wr <= 1'b0; out_rw_type <= '0;
      out_br <= '0; out_jal <= 1'b0; out_jalr <= 1'b0; out_illegal <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0; out_valid <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
      if (w_pop) begin
        out_valid <= 1'b1;
        out_pc <= r_q_pc[r_rd_ptr]; out_rs1 <= w_inst[19:15]; out_rs2 <= w_inst[24:20];
        out_rd <= w_inst[11:7]; out_imm <= w_imm; out_alu_ctl <= w_alu_ctl;
        out_alu_src1 <= w_src1; out_alu_src2 <= w_src2; out_wb_sel <= w_wb_sel;
        out_reg_wr <= w_reg_wr; out_mem_rd <= w_mem_rd; out_mem_wr <= w_mem_wr;
        out_rw_type <= w_rw_type; out_br <= w_br; out_jal <= w_jal; out_jalr <= w_jalr;
        out_illegal <= w_illegal;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run against a mnemonic-level decode model and a queue scoreboard.
module tb_decode_stage;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int CNT_W = 3;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic        src1, src2;
    logic [1:0]  wb;
    logic        reg_wr, mem_rd, mem_wr;
    logic [2:0]  rw;
    logic [5:0]  br;
    logic        jal, jalr, ill;
  } bundle_t;

  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic in_ready, out_valid;
  logic [XLEN-1:0] out_pc;
  logic [4:0] out_rs1, out_rs2, out_rd, out_alu_ctl;
  logic [31:0] out_imm;
  logic out_alu_src1, out_alu_src2, out_reg_wr, out_mem_rd, out_mem_wr;
  logic out_jal, out_jalr, out_illegal;
  logic [1:0] out_wb_sel;
  logic [2:0] out_rw_type;
  logic [5:0] out_br;
  logic [CNT_W-1:0] fifo_count;
  bundle_t got;

  int n_checks = 0;
  int n_fail = 0;
  int alu_of[string];

  decode_stage #(.DEPTH(DEPTH), .XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_alu_ctl(out_alu_ctl), .out_alu_src1(out_alu_src1),
    .out_alu_src2(out_alu_src2), .out_wb_sel(out_wb_sel), .out_reg_wr(out_reg_wr),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_rw_type(out_rw_type),
    .out_br(out_br), .out_jal(out_jal), .out_jalr(out_jalr), .out_illegal(out_illegal),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  assign got = {out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_ctl, out_alu_src1,
                out_alu_src2, out_wb_sel, out_reg_wr, out_mem_rd, out_mem_wr,
                out_rw_type, out_br, out_jal, out_jalr, out_illegal};

  function automatic string rname(input int f3);
    case (f3)
      0: return "add";  1: return "sll"; 2: return "slt"; 3: return "sltu";
      4: return "xor";  5: return "srl"; 6: return "or";  default: return "and";
    endcase
  endfunction

  function automatic string mname(input int f3);
    case (f3)
      0: return "mul"; 1: return "mulh"; 2: return "mulhsu"; 3: return "mulhu";
      4: return "div"; 5: return "divu"; 6: return "rem";    default: return "remu";
    endcase
  endfunction

  function automatic logic [31:0] sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return 32'(v - (1 << bits));
    return 32'(v);
  endfunction

  // Classify the word into a mnemonic/format first, then derive each field.
  function automatic bundle_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    bundle_t b;
    string kind, m;
    int op, f3, f7;
    b = '0; b.pc = pc; b.rs1 = w[19:15]; b.rs2 = w[24:20]; b.rd = w[11:7];
    op = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    kind = "ILL"; m = "";
    if (w[1:0] == 2'b11) begin
      case (op)
        'h37: kind = "lui";
        'h17: kind = "auipc";
        'h6F: kind = "jal";
        'h67: kind = "jalr";
        'h63: if (f3 != 2 && f3 != 3) kind = "branch";
        'h03: if (f3 != 3 && f3 < 6) kind = "load";
        'h23: if (f3 <= 2) kind = "store";
        'h13: begin
          if (f3 == 1)      m = (f7 == 0) ? "sll" : "";
          else if (f3 == 5) m = (f7 == 0) ? "srl" : (f7 == 32) ? "sra" : "";
          else              m = rname(f3);
          if (m != "") kind = "IA";
        end
        'h33: begin
          if (f7 == 0)                  m = rname(f3);
          else if (f7 == 32 && f3 == 0) m = "sub";
          else if (f7 == 32 && f3 == 5) m = "sra";
`ifdef DECODE_RVM_EN
          else if (f7 == 1)             m = mname(f3);
`endif
          if (m != "") kind = "R";
        end
        default: ;
      endcase
    end
    if (kind == "ILL") begin
      b.ill = 1'b1;
      return b;
    end
    if (m != "") b.alu = 5'(alu_of[m]);
    b.src1 = (kind == "branch" || kind == "auipc" || kind == "jal");
    b.src2 = (kind == "IA" || kind == "load" || kind == "jalr" || kind == "store" ||
              kind == "auipc" || kind == "jal" || kind == "branch");
    if (kind == "R" || kind == "IA" || kind == "auipc") b.wb = 2'd1;
    else if (kind == "lui")  b.wb = 2'd2;
    else if (kind == "load") b.wb = 2'd3;
    b.reg_wr = (kind != "branch" && kind != "store" && w[11:7] != 5'd0);
    b.mem_rd = (kind == "load");
    b.mem_wr = (kind == "store");
    if (kind == "load" || kind == "store") b.rw = 3'(f3);
    if (kind == "branch") b.br = 6'(1 << ((f3 < 4) ? f3 : f3 - 2));
    b.jal  = (kind == "jal");
    b.jalr = (kind == "jalr");
    if (kind == "IA" || kind == "load" || kind == "jalr") b.imm = sext(int'(w[31:20]), 12);
    else if (kind == "store") b.imm = sext(int'(w[31:25]) * 32 + int'(w[11:7]), 12);
    else if (kind == "branch")
      b.imm = sext(int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2, 13);
    else if (kind == "lui" || kind == "auipc") b.imm = w & 32'hFFFFF000;
    else if (kind == "jal")
      b.imm = sext(int'(w[31]) * (1 << 20) + int'(w[19:12]) * (1 << 12) + int'(w[20]) * (1 << 11) + int'(w[30:21]) * 2, 21);
    return b;
  endfunction

  function automatic logic [31:0] gen_inst();
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 9))
      0: w[6:0] = 7'h37; 1: w[6:0] = 7'h17; 2: w[6:0] = 7'h6F; 3: w[6:0] = 7'h67;
      4: w[6:0] = 7'h63; 5: w[6:0] = 7'h03; 6: w[6:0] = 7'h23; 7: w[6:0] = 7'h13;
      8: w[6:0] = 7'h33; default: ;
    endcase
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'h00; 1: w[31:25] = 7'h20; 2: w[31:25] = 7'h01; default: ;
    endcase
    return w;
  endfunction

  // Advance one clock; afterwards we sit just past the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b count=%0d ready=%b, expected 0/0/1", out_valid, fifo_count, in_ready);
    end
    n_checks++;
    if (got !== '0) begin
      n_fail++;
      $display("FAIL reset_bundle: got %h expected 0", got);
    end
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_addi();
    bundle_t exp;
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFFD00293; in_pc = 32'h100;
    exp = ref_decode(32'hFFD00293, 32'h100);
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd1) begin
      n_fail++;
      $display("FAIL addi_latency1: got valid=%b count=%0d expected 0/1", out_valid, fifo_count);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL addi_bundle: got valid=%b %h expected 1 %h", out_valid, got, exp);
    end
    n_checks++;
    if (out_rd !== 5'd5 || out_imm !== 32'hFFFFFFFD || out_alu_ctl !== 5'd0 ||
        out_alu_src2 !== 1'b1 || out_wb_sel !== 2'd1 || out_reg_wr !== 1'b1) begin
      n_fail++;
      $display("FAIL addi_fields: got rd=%0d imm=%h alu=%0d src2=%b wb=%0d wr=%b expected 5 fffffffd 0 1 1 1",
               out_rd, out_imm, out_alu_ctl, out_alu_src2, out_wb_sel, out_reg_wr);
    end
    step();
  endtask

  task automatic test_backpressure();
    logic [31:0] insts [5];
    bundle_t exp;
    insts[0] = 32'hFFD00293; insts[1] = 32'h022081B3; insts[2] = 32'h00208133;
    insts[3] = 32'h40208133; insts[4] = 32'h0040A183;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_inst = insts[i]; in_pc = 32'h200 + 32'(4 * i);
      step();
    end
    in_inst = 32'h00000013; in_pc = 32'h300;
    #1;
    n_checks++;
    if (fifo_count !== 3'd4 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL full_state: got count=%0d ready=%b valid=%b expected 4/0/1", fifo_count, in_ready, out_valid);
    end
    step();
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd4) begin
      n_fail++;
      $display("FAIL sixth_refused: got count=%0d expected 4", fifo_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp = ref_decode(insts[i], 32'h200 + 32'(4 * i));
      n_checks++;
      if (out_valid !== 1'b1 || got !== exp) begin
        n_fail++;
        $display("FAIL drain_%0d: got valid=%b %h expected 1 %h", i, out_valid, got, exp);
      end
      step();
    end
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL drain_empty: got valid=%b count=%0d expected 0/0", out_valid, fifo_count);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFE208CE3; in_pc = 32'h400;
    step();
    flush = 1'b1; in_inst = 32'h00100093; in_pc = 32'h404;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_ready: got %b expected 1", in_ready);
    end
    step();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin
      n_fail++;
      $display("FAIL flush_clear: got valid=%b count=%0d expected 0/0", out_valid, fifo_count);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_dropped_%0d: got valid=%b expected 0", i, out_valid);
      end
    end
  endtask

  task automatic test_mul();
    bundle_t exp;
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h022081B3; in_pc = 32'h500;
    exp = ref_decode(32'h022081B3, 32'h500);
    step();
    in_valid = 1'b0;
    step();
    n_checks++;
    if (out_valid !== 1'b1 || got !== exp) begin
      n_fail++;
      $display("FAIL mul_bundle: got valid=%b %h expected 1 %h", out_valid, got, exp);
    end
    n_checks++;
`ifdef DECODE_RVM_EN
    if (out_alu_ctl !== 5'd2 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL mul_fields: got alu=%0d ill=%b expected 2/0", out_alu_ctl, out_illegal);
    end
`else
    if (out_illegal !== 1'b1 || out_reg_wr !== 1'b0 || out_alu_ctl !== 5'd0) begin
      n_fail++;
      $display("FAIL mul_fields: got ill=%b wr=%b alu=%0d expected 1/0/0", out_illegal, out_reg_wr, out_alu_ctl);
    end
`endif
    step();
  endtask

  task automatic test_illegal_lui();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h00000000; in_pc = 32'h600;
    step();
    in_inst = 32'h12345037; in_pc = 32'h604;
    step();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_illegal !== 1'b1 || out_reg_wr !== 1'b0 ||
        out_mem_rd !== 1'b0 || out_mem_wr !== 1'b0 || out_br !== 6'd0 || out_jal !== 1'b0 || out_jalr !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_word: got valid=%b ill=%b wr=%b rd=%b wr=%b br=%b jal=%b jalr=%b expected 1 1 0 0 0 0 0 0",
               out_valid, out_illegal, out_reg_wr, out_mem_rd, out_mem_wr, out_br, out_jal, out_jalr);
    end
    step();
    n_checks++;
    if (out_valid !== 1'b1 || out_imm !== 32'h12345000 || out_wb_sel !== 2'd2 ||
        out_reg_wr !== 1'b0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL lui_x0: got valid=%b imm=%h wb=%0d wr=%b ill=%b expected 1 12345000 2 0 0",
               out_valid, out_imm, out_wb_sel, out_reg_wr, out_illegal);
    end
    step();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_inst = 32'h00000013 + 32'(i << 7); in_pc = 32'h700 + 32'(4 * i);
      step();
    end
    in_valid = 1'b0;
    n_checks++;
    if (fifo_count !== 3'd3 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got count=%0d valid=%b expected 3/1", fifo_count, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || fifo_count !== 3'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset: got valid=%b count=%0d ready=%b expected 0/0/1", out_valid, fifo_count, in_ready);
    end
    #1 rst = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [63:0] sb[$];
    bundle_t exp;
    logic acc, cons;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_inst   = gen_inst();
      in_pc     = $urandom;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      #1;
      if (out_valid) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL rand_phantom_%0d: got valid=1 %h expected empty stage", c, got);
        end else begin
          exp = ref_decode(sb[0][63:32], sb[0][31:0]);
          if (got !== exp) begin
            n_fail++;
            $display("FAIL rand_bundle_%0d: got %h expected %h", c, got, exp);
          end
        end
      end
      n_checks++;
      if (int'(fifo_count) !== sb.size() - int'(out_valid)) begin
        n_fail++;
        $display("FAIL rand_count_%0d: got %0d expected %0d", c, fifo_count, sb.size() - int'(out_valid));
      end
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (flush) sb.delete();
      else begin
        if (cons && sb.size() != 0) void'(sb.pop_front());
        if (acc) sb.push_back({in_inst, in_pc});
      end
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    alu_of["add"] = 0;  alu_of["sub"] = 1;  alu_of["mul"] = 2;   alu_of["mulh"] = 3;
    alu_of["mulhsu"] = 4; alu_of["mulhu"] = 5; alu_of["div"] = 6; alu_of["divu"] = 7;
    alu_of["rem"] = 8;  alu_of["remu"] = 9; alu_of["and"] = 10;  alu_of["or"] = 11;
    alu_of["xor"] = 12; alu_of["sll"] = 14; alu_of["srl"] = 15;  alu_of["sra"] = 16;
    alu_of["sltu"] = 17; alu_of["slt"] = 18;
    test_reset();
    test_addi();
    test_backpressure();
    test_flush();
    test_mul();
    test_illegal_lui();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
